// File: rtl/result_tx_pkg.sv
// ============================================================================
// Module   : result_tx_pkg
// Purpose  : Shared types and constants for the result transmit serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package result_tx_pkg;

  localparam int BYTE_W     = 8;
  localparam int MAX_DATA_W = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } tx_state_t;

  // A request of 0 or anything beyond the word size means "send the whole word".
  function automatic logic [3:0] clamp_len(input logic [3:0] req, input logic [3:0] max_bytes);
    return ((req == 4'd0) || (req > max_bytes)) ? max_bytes : req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/result_tx_serializer_if.sv
// ============================================================================
// Module   : result_tx_serializer_if
// Purpose  : Control-unit request/ack and UART byte handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface result_tx_serializer_if #(
  parameter int DATA_W = 32
);
  import result_tx_pkg::*;

  logic              tx_start;
  logic [DATA_W-1:0] result_data;
  logic [3:0]        num_bytes;
  logic              tx_sent;
  logic              busy;
  logic [BYTE_W-1:0] uart_tx_data;
  logic              uart_tx_start;
  logic              uart_tx_busy;

  modport slave (
    input  tx_start, result_data, num_bytes, uart_tx_busy,
    output tx_sent, busy, uart_tx_data, uart_tx_start
  );

  modport master (
    output tx_start, result_data, num_bytes, uart_tx_busy,
    input  tx_sent, busy, uart_tx_data, uart_tx_start
  );

endinterface

`default_nettype wire

// File: rtl/result_tx_serializer.sv
// ============================================================================
// Module   : result_tx_serializer
// Purpose  : Splits a latched result word into bytes (LSB first) for the UART
//            and acknowledges the control unit once the last byte has left.
//            Optional trailing XOR checksum byte: define RESULT_TX_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_tx_serializer
  import result_tx_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              reset,
  result_tx_serializer_if.slave  bus
);

  localparam logic [3:0] c_NUM_BYTES = 4'(DATA_W / BYTE_W);

  tx_state_t         r_state;
  tx_state_t         w_next_state;
  logic [DATA_W-1:0] r_shreg;
  logic [3:0]        r_len;
  logic [3:0]        r_idx;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_tx_start;

  logic              w_accept;
  logic              w_issue;
  logic              w_byte_done;
  logic [3:0]        w_total;
  logic [BYTE_W-1:0] w_issue_byte;

`ifdef RESULT_TX_CHECKSUM_EN
  logic [BYTE_W-1:0] r_csum;
  logic              w_is_csum;

  // The checksum rides as one extra frame slot at index len.
  assign w_is_csum    = (r_idx == r_len);
  assign w_total      = r_len + 4'd1;
  assign w_issue_byte = w_is_csum ? r_csum : r_shreg[BYTE_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= '0;
    end else if (w_issue && !w_is_csum) begin
      r_csum <= r_csum ^ r_shreg[BYTE_W-1:0];
    end
  end
`else
  assign w_total      = r_len;
  assign w_issue_byte = r_shreg[BYTE_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_byte_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.tx_start) begin
          w_accept     = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.uart_tx_busy) begin
          w_issue      = 1'b1;
          w_next_state = WAIT_ACK;
        end
      end
      // UART busy only rises the cycle after the strobe, so it is not meaningful here.
      WAIT_ACK: begin
        w_next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.uart_tx_busy) begin
          w_byte_done  = 1'b1;
          w_next_state = ((r_idx + 4'd1) == w_total) ? DONE : ISSUE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg    <= '0;
      r_len      <= 4'd0;
      r_idx      <= 4'd0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= w_issue;
      if (w_accept) begin
        r_shreg <= bus.result_data;
        r_len   <= clamp_len(bus.num_bytes, c_NUM_BYTES);
        r_idx   <= 4'd0;
      end
      if (w_issue) begin
        r_tx_data <= w_issue_byte;
      end
      if (w_byte_done) begin
        r_shreg <= r_shreg >> BYTE_W;
        r_idx   <= r_idx + 4'd1;
      end
    end
  end

  assign bus.tx_sent       = (r_state == DONE);
  assign bus.busy          = (r_state != IDLE);
  assign bus.uart_tx_data  = r_tx_data;
  assign bus.uart_tx_start = r_tx_start;

endmodule

`default_nettype wire
